fwd_hazard_scoreboard: RTL and testbench
========================================

Name: fwd_hazard_scoreboard

Overview:
Parametrised forwarding and load-use hazard unit for the pipelined core.
- Tracks every in-flight register write from EX through DEPTH downstream stages in an internal shift register (stage 1 = MEM, stage 2 = WB, and so on).
- Drives bypass-mux selects for NSRC source operands of the instruction in EX.
- Asserts stall when the youngest matching producer's result is not yet available, such as load-use.
- Replaces fixed two-operand, two-stage forwarding with configurable depth, operand count and per-instruction result latency.

Parameters:
- AW, 5, register address width.
- NSRC, 2, number of source operands checked per EX instruction.
- DEPTH, 3, number of tracked stages after EX; must be at least 1.
- SELW, $clog2(DEPTH+1), width of each select field and of the availability field.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- ex_valid  input  1  EX holds a real instruction.
- ex_src  input  NSRC*AW  source register addresses; operand i occupies bits [i*AW +: AW].
- ex_src_used  input  NSRC  bit i set means operand i is actually read.
- ex_regwrite  input  1  EX instruction writes a register.
- ex_dst  input  AW  destination register of the EX instruction.
- ex_avail  input  SELW  first stage index at which the result can be forwarded: 1 for ALU ops, 2 for loads.
- advance  input  1  pipeline moves this cycle; 0 is a global freeze.
- flush  input  1  kill the EX instruction; it does not enter stage 1.
- fwd_sel  output  NSRC*SELW  per operand: 0 = register file, k = forward from stage k.
- stall  output  1  EX instruction must hold; a bubble is inserted into stage 1.

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Entry per stage k (1..DEPTH) holds: vld, dst[AW], avail[SELW].
  - Entry k is live when vld is set and dst is non-zero. Register 0 is never forwarded and never stalls.
- Reset: all vld cleared. Consequently fwd_sel = 0 and stall = 0 in the cycle after reset and while rst_n is low. Reset overrides advance and flush.
- Combinational lookup, per operand i:
  - Skipped when ex_valid = 0 or ex_src_used[i] = 0. That operand gives sel = 0 and no stall.
  - Search k = 1..DEPTH for a live entry with dst == src_i. The smallest k wins (youngest producer).
  - If the winner has avail <= k: sel_i = k.
  - If the winner has avail > k: sel_i = 0 and stall contribution 1. Do not fall through to older matches.
  - No match: sel_i = 0.
  - stall = OR of all operand contributions.
  - Outputs change in the same cycle as the inputs; no added latency.
- Shift, at the clock edge with rst_n = 1:
  - advance = 1: stage k takes stage k-1 for k = 2..DEPTH; the old stage DEPTH entry retires.
  - Stage 1 load rule:
    - If advance && ex_valid && ex_regwrite && !stall && !flush: load {1, ex_dst, ex_avail}.
    - Otherwise, if advance = 1: load a bubble (vld = 0).
  - advance = 0 and flush = 0: all entries hold.
  - advance = 0 and flush = 1: all entries hold. Flush only blocks entry; it never clears older stages.
- Stall and advance together: older stages shift and stage 1 gets a bubble. The same EX instruction is re-evaluated next cycle, and the producer is now one stage older.
- ex_avail = 0 is treated as 1.
- ex_avail > DEPTH: the result is never forwardable from tracked stages. The consumer stalls until the producer retires, then reads the register file.
- A duplicate dst in several stages resolves to the youngest.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- When defined, two output ports are added:
  - perf_stall_cnt[31:0]: counts cycles with stall = 1 and advance = 1.
  - perf_fwd_cnt[31:0]: counts cycles with advance = 1 where any operand has a non-zero select.
- Both counters saturate at 32'hFFFFFFFF and clear on reset.
- When undefined, the ports and logic are absent and the lookup/shift behaviour is identical.

Test Plan:
- Reset:
  - Stimulus: drive ex_valid = 1, src0 = 3, with all entries previously valid; hold rst_n = 0 for 2 cycles.
  - Required: fwd_sel = 0 and stall = 0 in those cycles and in the first cycle after release.
- ALU back-to-back:
  - Stimulus: issue regwrite dst = 5, avail = 1 with advance = 1; next cycle EX reads src0 = 5, src1 = 5.
  - Required: both selects = 1, stall = 0. One cycle later, if still in EX under advance = 0 freeze: selects stay 1.
- Load-use:
  - Stimulus: issue dst = 8, avail = 2; next cycle EX reads src1 = 8.
  - Required: stall = 1 for exactly one cycle; after that edge, sel1 = 2 and stall = 0.
- Youngest wins:
  - Stimulus: stage 1 dst = 4, stage 2 dst = 4, both avail = 1; EX reads src0 = 4.
  - Required: sel0 = 1.
  - Repeat with stage 1 avail = 2: required stall = 1, not sel = 2.
- Zero register and unused operands:
  - Stimulus: stage 1 dst = 0 with src0 = 0; separately stage 1 dst = 7 with src0 = 7 and ex_src_used[0] = 0.
  - Required: sel0 = 0 and stall = 0 in both cases.
- Flush and freeze:
  - Stimulus: flush = 1 with advance = 1 on a dst = 9 writer; the next instruction reads 9.
  - Required: sel = 0.
  - Stimulus: advance = 0 for 3 cycles.
  - Required: entries and selects unchanged.
  - With FWD_HAZARD_PERF_EN defined: perf_stall_cnt increments only on stall && advance cycles.

Source files
------------

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and load-use hazard unit: tracks in-flight writers for DEPTH stages past EX.
// Optional performance counters are built when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_scoreboard #(
    parameter int AW    = 5,
    parameter int NSRC  = 2,
    parameter int DEPTH = 3,
    parameter int SELW  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic [NSRC*AW-1:0]   ex_src,
    input  logic [NSRC-1:0]      ex_src_used,
    input  logic                 ex_regwrite,
    input  logic [AW-1:0]        ex_dst,
    input  logic [SELW-1:0]      ex_avail,
    input  logic                 advance,
    input  logic                 flush,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic                 stall
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_fwd_cnt
`endif
);

    logic            r_vld   [1:DEPTH];
    logic [AW-1:0]   r_dst   [1:DEPTH];
    logic [SELW-1:0] r_avail [1:DEPTH];

    logic [SELW-1:0] w_sel [NSRC];
    logic [NSRC-1:0] w_stall_op;
    logic [SELW-1:0] w_ex_avail;
    logic            w_load;

    assign w_ex_avail = (ex_avail == '0) ? SELW'(1) : ex_avail;
    assign w_load     = ex_valid && ex_regwrite && !stall && !flush;

    // Oldest-to-youngest scan so the smallest matching stage overwrites the rest.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            w_sel[i]      = '0;
            w_stall_op[i] = 1'b0;
            if (rst_n && ex_valid && ex_src_used[i]) begin
                for (int k = DEPTH; k >= 1; k--) begin
                    if (r_vld[k] && (r_dst[k] != '0) &&
                        (r_dst[k] == ex_src[i*AW +: AW])) begin
                        if (r_avail[k] <= SELW'(k)) begin
                            w_sel[i]      = SELW'(k);
                            w_stall_op[i] = 1'b0;
                        end else begin
                            w_sel[i]      = '0;
                            w_stall_op[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            fwd_sel[i*SELW +: SELW] = w_sel[i];
        end
        stall = |w_stall_op;
    end

    // A freeze holds every stage; flush only keeps the EX instruction out of stage 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_vld[k]   <= 1'b0;
                r_dst[k]   <= '0;
                r_avail[k] <= '0;
            end
        end else if (advance) begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_vld[k]   <= r_vld[k-1];
                r_dst[k]   <= r_dst[k-1];
                r_avail[k] <= r_avail[k-1];
            end
            r_vld[1]   <= w_load;
            r_dst[1]   <= ex_dst;
            r_avail[1] <= w_ex_avail;
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (stall && advance && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (advance && (|fwd_sel) && (perf_fwd_cnt != 32'hFFFF_FFFF)) begin
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard: expected {stall, fwd_sel} words are
// queued as each step is driven and popped when the combinational outputs are sampled.
module tb_fwd_hazard_scoreboard;

    localparam int AW    = 5;
    localparam int NSRC  = 2;
    localparam int DEPTH = 3;
    localparam int SELW  = 2;
    localparam int EW    = 1 + NSRC*SELW;

    logic                 clk;
    logic                 rst_n;
    logic                 ex_valid;
    logic [NSRC*AW-1:0]   ex_src;
    logic [NSRC-1:0]      ex_src_used;
    logic                 ex_regwrite;
    logic [AW-1:0]        ex_dst;
    logic [SELW-1:0]      ex_avail;
    logic                 advance;
    logic                 flush;
    logic [NSRC*SELW-1:0] fwd_sel;
    logic                 stall;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0]          perf_stall_cnt;
    logic [31:0]          perf_fwd_cnt;
`endif

    logic [EW-1:0] exp_q[$];
    int            total;
    int            bad;
    logic [AW-1:0] d;

    fwd_hazard_scoreboard #(
        .AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .SELW(SELW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ex_valid(ex_valid),
        .ex_src(ex_src),
        .ex_src_used(ex_src_used),
        .ex_regwrite(ex_regwrite),
        .ex_dst(ex_dst),
        .ex_avail(ex_avail),
        .advance(advance),
        .flush(flush),
        .fwd_sel(fwd_sel),
        .stall(stall)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_fwd_cnt(perf_fwd_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic drive(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                         input logic [1:0] used, input logic rw, input logic [AW-1:0] dst,
                         input logic [SELW-1:0] av, input logic adv, input logic fl);
        ex_valid    = v;
        ex_src      = {s1, s0};
        ex_src_used = used;
        ex_regwrite = rw;
        ex_dst      = dst;
        ex_avail    = av;
        advance     = adv;
        flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_pipe();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd1, 1'b1, 1'b0);
        repeat (DEPTH) tick();
    endtask

    // scoreboard: push expectation, let combinational outputs settle, pop and compare
    task automatic expect_out(input string tag, input logic st,
                              input logic [SELW-1:0] sel1, input logic [SELW-1:0] sel0);
        logic [EW-1:0] obs;
        logic [EW-1:0] exp_v;
        exp_q.push_back({st, sel1, sel0});
        #1;
        obs   = {stall, fwd_sel};
        exp_v = exp_q.pop_front();
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed={stall,sel1,sel0}=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        repeat (2) tick();
        rst_n = 1'b1;

        // fill every stage with a writer of r3, then reset while EX reads r3
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 2'd1, 1'b1, 1'b0);
        repeat (DEPTH) tick();
        drive(1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 2'd1, 1'b1, 1'b0);
        expect_out("fill", 1'b0, 2'd0, 2'd1);
        rst_n = 1'b0;
        expect_out("rst_low0", 1'b0, 2'd0, 2'd0);
        tick();
        expect_out("rst_low1", 1'b0, 2'd0, 2'd0);
        tick();
        rst_n = 1'b1;
        expect_out("rst_rel", 1'b0, 2'd0, 2'd0);
        tick();

        // ALU back-to-back, freeze, then ageing into WB
        d = AW'($urandom_range(1, 31));
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, d, 2'd1, 1'b1, 1'b0);
        expect_out("alu_issue", 1'b0, 2'd0, 2'd0);
        tick();
        drive(1'b1, d, d, 2'b11, 1'b0, 5'd0, 2'd1, 1'b0, 1'b0);
        expect_out("alu_b2b", 1'b0, 2'd1, 2'd1);
        tick();
        expect_out("alu_freeze", 1'b0, 2'd1, 2'd1);
        drive(1'b1, d, d, 2'b11, 1'b0, 5'd0, 2'd1, 1'b1, 1'b0);
        tick();
        expect_out("alu_age2", 1'b0, 2'd2, 2'd2);
        clear_pipe();

        // load-use: one stall cycle, then forward from WB
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd8, 2'd2, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd8, 2'b10, 1'b0, 5'd0, 2'd1, 1'b1, 1'b0);
        expect_out("lu_stall", 1'b1, 2'd0, 2'd0);
        tick();
        expect_out("lu_fwd", 1'b0, 2'd2, 2'd0);
        clear_pipe();

        // youngest producer wins, both when forwardable and when it stalls
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 2'd1, 1'b1, 1'b0);
        repeat (2) tick();
        drive(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 2'd1, 1'b0, 1'b0);
        expect_out("yw_alu", 1'b0, 2'd0, 2'd1);
        clear_pipe();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 2'd1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 2'd2, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 2'd1, 1'b0, 1'b0);
        expect_out("yw_load", 1'b1, 2'd0, 2'd0);
        for (int n = 0; n < 3; n++) begin
            tick();
            expect_out($sformatf("freeze_%0d", n), 1'b1, 2'd0, 2'd0);
        end
        clear_pipe();

        // zero register, unused operand, invalid EX
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 2'd1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b01, 1'b0, 5'd0, 2'd1, 1'b0, 1'b0);
        expect_out("zero_reg", 1'b0, 2'd0, 2'd0);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 2'd1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd7, 5'd0, 2'b00, 1'b0, 5'd0, 2'd1, 1'b0, 1'b0);
        expect_out("unused", 1'b0, 2'd0, 2'd0);
        drive(1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 2'd1, 1'b0, 1'b0);
        expect_out("used_ctrl", 1'b0, 2'd0, 2'd1);
        drive(1'b0, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 2'd1, 1'b0, 1'b0);
        expect_out("invalid", 1'b0, 2'd0, 2'd0);
        clear_pipe();

        // flush blocks entry but leaves older stages alone
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 2'd1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd9, 5'd9, 2'b11, 1'b0, 5'd0, 2'd1, 1'b1, 1'b0);
        expect_out("flush_blk", 1'b0, 2'd0, 2'd0);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd10, 2'd1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd11, 2'd1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd10, 5'd11, 2'b11, 1'b0, 5'd0, 2'd1, 1'b0, 1'b0);
        expect_out("flush_keep", 1'b0, 2'd0, 2'd2);
        clear_pipe();

        // avail = 0 behaves as 1; avail = 3 stalls until stage 3
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd12, 2'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd12, 5'd0, 2'b01, 1'b0, 5'd0, 2'd1, 1'b0, 1'b0);
        expect_out("avail0", 1'b0, 2'd0, 2'd1);
        clear_pipe();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd13, 2'd3, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd13, 2'b10, 1'b0, 5'd0, 2'd1, 1'b1, 1'b0);
        expect_out("av3_s1", 1'b1, 2'd0, 2'd0);
        tick();
        expect_out("av3_s2", 1'b1, 2'd0, 2'd0);
        tick();
        expect_out("av3_s3", 1'b0, 2'd3, 2'd0);
        clear_pipe();

        // a stalled writer must not enter stage 1 until it proceeds
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd20, 2'd2, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd20, 5'd21, 2'b11, 1'b1, 5'd21, 2'd1, 1'b1, 1'b0);
        expect_out("sb_stall", 1'b1, 2'd0, 2'd0);
        tick();
        expect_out("sb_go", 1'b0, 2'd0, 2'd2);
        tick();
        drive(1'b1, 5'd21, 5'd0, 2'b01, 1'b0, 5'd0, 2'd1, 1'b0, 1'b0);
        expect_out("sb_load", 1'b0, 2'd0, 2'd1);

`ifdef FWD_HAZARD_PERF_EN
        total++;
        assert (perf_stall_cnt === 32'd4) else begin
            bad++;
            $error("FAIL perf_stall observed=%0d expected=%0d", perf_stall_cnt, 4);
        end
`endif

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
